// File: rtl/snake_core_gen.sv
// Snake game engine: one move per tick, apple re-roll, reversal rejection.
// Define SNAKE_WRAP_EN to wrap at the grid edges instead of dying there.
module snake_core_gen #(
    parameter  int GRID_COLS = 16,
    parameter  int GRID_ROWS = 16,
    parameter  int MAX_LEN   = 9,
    parameter  int START_LEN = 3,
    parameter  int SCORE_W   = 4,
    localparam int COL_W     = $clog2(GRID_COLS),
    localparam int ROW_W     = $clog2(GRID_ROWS),
    localparam int POS_W     = ROW_W + COL_W,
    localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     up,
    input  logic                     right,
    input  logic                     left,
    input  logic                     down,
    input  logic [POS_W-1:0]         rand_num,
    output logic [MAX_LEN*POS_W-1:0] snake,
    output logic [MAX_LEN-1:0]       seg_valid,
    output logic [LEN_W-1:0]         length,
    output logic [POS_W-1:0]         apple,
    output logic [SCORE_W-1:0]       score,
    output logic                     score_flag,
    output logic                     dead_flag,
    output logic                     win_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PLACE,
        S_DEAD,
        S_WIN
    } state_t;

    // Encoding chosen so the opposite direction is the bitwise inverse.
    typedef enum logic [1:0] {
        D_UP    = 2'd0,
        D_RIGHT = 2'd1,
        D_LEFT  = 2'd2,
        D_DOWN  = 2'd3
    } dir_t;

    state_t           state;
    dir_t             dir;
    dir_t             next_dir;
    logic             pending;
    logic [POS_W-1:0] seg    [MAX_LEN];
    logic [POS_W-1:0] seg_sh [MAX_LEN];

    function automatic logic [POS_W-1:0] rst_seg(input int i);
        if (i < START_LEN)
            return {ROW_W'(GRID_ROWS / 2), COL_W'(GRID_COLS / 2 - i)};
        return '0;
    endfunction

    function automatic logic [MAX_LEN-1:0] len_mask(input int n);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++)
            m[i] = (i < n);
        return m;
    endfunction

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_out
        assign snake[g*POS_W +: POS_W] = seg[g];
    end

    logic req_v;
    dir_t req_dir;

    always_comb begin
        req_v   = 1'b1;
        req_dir = D_UP;
        if (up)
            req_dir = D_UP;
        else if (right)
            req_dir = D_RIGHT;
        else if (left)
            req_dir = D_LEFT;
        else if (down)
            req_dir = D_DOWN;
        else
            req_v = 1'b0;
        if (req_dir == dir_t'(~dir))
            req_v = 1'b0;
    end

    logic [ROW_W-1:0] h_row;
    logic [COL_W-1:0] h_col;
    logic [ROW_W-1:0] n_row;
    logic [COL_W-1:0] n_col;
    logic             at_wall;
    logic             off_grid;
    logic [POS_W-1:0] head_n;

    assign {h_row, h_col} = seg[0];

    always_comb begin
        n_row   = h_row;
        n_col   = h_col;
        at_wall = 1'b0;
        unique case (next_dir)
            D_UP: begin
                if (h_row == '0) begin
                    at_wall = 1'b1;
                    n_row   = ROW_W'(GRID_ROWS - 1);
                end else begin
                    n_row = h_row - ROW_W'(1);
                end
            end
            D_DOWN: begin
                if (h_row == ROW_W'(GRID_ROWS - 1)) begin
                    at_wall = 1'b1;
                    n_row   = '0;
                end else begin
                    n_row = h_row + ROW_W'(1);
                end
            end
            D_LEFT: begin
                if (h_col == '0) begin
                    at_wall = 1'b1;
                    n_col   = COL_W'(GRID_COLS - 1);
                end else begin
                    n_col = h_col - COL_W'(1);
                end
            end
            D_RIGHT: begin
                if (h_col == COL_W'(GRID_COLS - 1)) begin
                    at_wall = 1'b1;
                    n_col   = '0;
                end else begin
                    n_col = h_col + COL_W'(1);
                end
            end
            default: ;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign off_grid = 1'b0;
`else
    assign off_grid = at_wall;
`endif

    assign head_n = {n_row, n_col};

    logic eat;
    logic hit;
    int   shift_len;

    assign eat       = (head_n == apple);
    assign shift_len = eat ? int'(length) + 1 : int'(length);

    // The tail cell is vacating this move, so it is excluded.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(length) - 1 && seg[i] == head_n)
                hit = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i >= shift_len)
                seg_sh[i] = '0;
            else if (i == 0)
                seg_sh[i] = head_n;
            else
                seg_sh[i] = seg[i-1];
        end
    end

    logic [ROW_W-1:0] c_row;
    logic [COL_W-1:0] c_col;
    logic             c_busy;
    logic             c_ok;

    assign c_row = rand_num[POS_W-1:COL_W];
    assign c_col = rand_num[COL_W-1:0];

    always_comb begin
        c_busy = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (seg_valid[i] && seg[i] == rand_num)
                c_busy = 1'b1;
    end

    assign c_ok = !c_busy
               && int'(c_col) < GRID_COLS
               && int'(c_row) < GRID_ROWS;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            dir        <= D_RIGHT;
            next_dir   <= D_RIGHT;
            pending    <= 1'b0;
            length     <= LEN_W'(START_LEN);
            seg_valid  <= len_mask(START_LEN);
            apple      <= {ROW_W'(GRID_ROWS / 2), COL_W'(GRID_COLS - 2)};
            score      <= '0;
            score_flag <= 1'b0;
            dead_flag  <= 1'b0;
            win_flag   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++)
                seg[i] <= rst_seg(i);
        end else begin
            score_flag <= 1'b0;
            if (req_v)
                next_dir <= req_dir;
            unique case (state)
                S_IDLE: begin
                    if (req_v)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (tick || pending) begin
                        pending <= 1'b0;
                        dir     <= next_dir;
                        if (off_grid) begin
                            state     <= S_DEAD;
                            dead_flag <= 1'b1;
                        end else if (eat) begin
                            seg        <= seg_sh;
                            length     <= length + LEN_W'(1);
                            seg_valid  <= len_mask(shift_len);
                            score_flag <= 1'b1;
                            if (score != '1)
                                score <= score + SCORE_W'(1);
                            if (shift_len == MAX_LEN) begin
                                state    <= S_WIN;
                                win_flag <= 1'b1;
                            end else begin
                                state <= S_PLACE;
                            end
                        end else if (hit) begin
                            state     <= S_DEAD;
                            dead_flag <= 1'b1;
                        end else begin
                            seg <= seg_sh;
                        end
                    end
                end
                S_PLACE: begin
                    if (tick)
                        pending <= 1'b1;
                    if (c_ok) begin
                        apple <= rand_num;
                        state <= S_RUN;
                    end
                end
                S_DEAD: ;
                S_WIN: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_core_gen.sv
// Bench for snake_core_gen: scripted scenarios plus a random walk
// checked against a queue-based model of the game rules.
module tb_snake_core_gen;

    localparam int COLS = 16;
    localparam int ROWS = 16;
    localparam int ML   = 9;
    localparam int SL   = 3;
    localparam int SW   = 4;
    localparam int CW   = 4;
    localparam int PW   = 8;
    localparam int LW   = 4;

    logic          clk = 0;
    logic          rst = 1;
    logic          tick = 0;
    logic          up = 0, right = 0, left = 0, down = 0;
    logic [PW-1:0] rand_num = '0;
    logic [ML*PW-1:0] snake;
    logic [ML-1:0] seg_valid;
    logic [LW-1:0] length;
    logic [PW-1:0] apple;
    logic [SW-1:0] score;
    logic          score_flag, dead_flag, win_flag;

    logic          w_rst = 1;
    logic          w_tick = 0;
    logic          w_right = 0;
    logic [PW-1:0] w_rand = '0;
    logic [4*PW-1:0] w_snake;
    logic [3:0]    w_seg_valid;
    logic [2:0]    w_length;
    logic [PW-1:0] w_apple;
    logic [SW-1:0] w_score;
    logic          w_sflag, w_dead, w_win;

    int n_checks = 0;
    int n_fail   = 0;

    snake_core_gen dut (
        .clk(clk), .rst(rst), .tick(tick),
        .up(up), .right(right), .left(left), .down(down),
        .rand_num(rand_num), .snake(snake), .seg_valid(seg_valid),
        .length(length), .apple(apple), .score(score),
        .score_flag(score_flag), .dead_flag(dead_flag),
        .win_flag(win_flag)
    );

    snake_core_gen #(.MAX_LEN(4)) dut_w (
        .clk(clk), .rst(w_rst), .tick(w_tick),
        .up(1'b0), .right(w_right), .left(1'b0), .down(1'b0),
        .rand_num(w_rand), .snake(w_snake), .seg_valid(w_seg_valid),
        .length(w_length), .apple(w_apple), .score(w_score),
        .score_flag(w_sflag), .dead_flag(w_dead), .win_flag(w_win)
    );

    always #5 clk = ~clk;

    // Model state: 0 idle, 1 run, 2 place, 3 dead, 4 win.
    // Directions: 0 up, 1 right, 2 left, 3 down.
    int m_state, m_dir, m_ndir, m_score, m_ar, m_ac;
    bit m_sflag, m_pend;
    int m_r[$];
    int m_c[$];

    function automatic logic [PW-1:0] pos(input int r, input int c);
        return PW'(r * (1 << CW) + c);
    endfunction

    function automatic logic [ML*PW-1:0] m_vec();
        logic [ML*PW-1:0] v;
        v = '0;
        for (int i = 0; i < m_r.size(); i++)
            v[i*PW +: PW] = pos(m_r[i], m_c[i]);
        return v;
    endfunction

    function automatic logic [ML*PW-1:0] m_pmask();
        logic [ML*PW-1:0] v;
        v = '0;
        for (int i = 0; i < m_r.size(); i++)
            v[i*PW +: PW] = '1;
        return v;
    endfunction

    task automatic m_reset();
        m_state = 0; m_dir = 1; m_ndir = 1; m_score = 0;
        m_sflag = 0; m_pend = 0;
        m_ar = ROWS / 2; m_ac = COLS - 2;
        m_r.delete(); m_c.delete();
        for (int i = 0; i < SL; i++) begin
            m_r.push_back(ROWS / 2);
            m_c.push_back(COLS / 2 - i);
        end
    endtask

    task automatic m_move();
        int nr, nc;
        bit hit;
        nr = m_r[0] + (m_ndir == 3 ? 1 : 0) - (m_ndir == 0 ? 1 : 0);
        nc = m_c[0] + (m_ndir == 1 ? 1 : 0) - (m_ndir == 2 ? 1 : 0);
        m_dir = m_ndir;
`ifdef SNAKE_WRAP_EN
        nr = (nr + ROWS) % ROWS;
        nc = (nc + COLS) % COLS;
`endif
        if (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS) begin
            m_state = 3;
            return;
        end
        if (nr == m_ar && nc == m_ac) begin
            m_r.push_front(nr);
            m_c.push_front(nc);
            if (m_score < (1 << SW) - 1) m_score++;
            m_sflag = 1;
            m_state = (m_r.size() == ML) ? 4 : 2;
            return;
        end
        hit = 0;
        for (int i = 0; i < m_r.size() - 1; i++)
            if (m_r[i] == nr && m_c[i] == nc) hit = 1;
        if (hit) begin
            m_state = 3;
            return;
        end
        m_r.push_front(nr); m_c.push_front(nc);
        void'(m_r.pop_back()); void'(m_c.pop_back());
    endtask

    task automatic m_clk();
        int d, cr, cc;
        bit p, busy;
        p = 1; d = 0;
        if (up) d = 0;
        else if (right) d = 1;
        else if (left) d = 2;
        else if (down) d = 3;
        else p = 0;
        if (p && d == 3 - m_dir) p = 0;
        m_sflag = 0;
        case (m_state)
            0: if (p) m_state = 1;
            1: if (tick || m_pend) begin
                m_pend = 0;
                m_move();
            end
            2: begin
                if (tick) m_pend = 1;
                cr = int'(rand_num) / (1 << CW);
                cc = int'(rand_num) % (1 << CW);
                busy = 0;
                for (int i = 0; i < m_r.size(); i++)
                    if (m_r[i] == cr && m_c[i] == cc) busy = 1;
                if (!busy && cr < ROWS && cc < COLS) begin
                    m_ar = cr; m_ac = cc; m_state = 1;
                end
            end
            default: ;
        endcase
        if (p) m_ndir = d;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) m_reset();
        else m_clk();
        #1;
    endtask

    task automatic test_reset();
        logic [ML*PW-1:0] e;
        rst = 1; step(); step(); rst = 0;
        e = '0;
        e[7:0] = 8'h88; e[15:8] = 8'h87; e[23:16] = 8'h86;
        n_checks++; if (snake !== e) begin n_fail++;
            $display("FAIL reset_snake: got %h exp %h", snake, e); end
        n_checks++; if (seg_valid !== 9'h007) begin n_fail++;
            $display("FAIL reset_valid: got %h exp 007", seg_valid); end
        n_checks++; if (length !== 4'd3) begin n_fail++;
            $display("FAIL reset_len: got %0d exp 3", length); end
        n_checks++; if (apple !== 8'h8E) begin n_fail++;
            $display("FAIL reset_apple: got %h exp 8e", apple); end
        n_checks++; if ({score, score_flag, dead_flag, win_flag} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: got %h %b%b%b exp 0 000",
                     score, score_flag, dead_flag, win_flag); end
    endtask

    task automatic test_idle();
        left = 1; step(); left = 0;
        tick = 1; repeat (3) step(); tick = 0;
        n_checks++; if (snake[23:0] !== 24'h868788) begin n_fail++;
            $display("FAIL idle_frozen: got %h exp 868788", snake[23:0]); end
    endtask

    task automatic test_start();
        right = 1; step(); right = 0;
        tick = 1; step(); tick = 0;
        n_checks++; if (snake[23:0] !== 24'h878889) begin n_fail++;
            $display("FAIL start_move: got %h exp 878889", snake[23:0]); end
    endtask

    task automatic test_reversal();
        left = 1; step(); step();
        tick = 1; step(); tick = 0; left = 0;
        n_checks++; if (snake[7:0] !== 8'h8A) begin n_fail++;
            $display("FAIL rev_reject: got %h exp 8a", snake[7:0]); end
        tick = 1; step(); tick = 0;
        n_checks++; if (snake[7:0] !== 8'h8B) begin n_fail++;
            $display("FAIL rev_dir_kept: got %h exp 8b", snake[7:0]); end
    endtask

    task automatic test_eat();
        int pulses;
        rand_num = 8'h8C;
        tick = 1; repeat (3) step(); tick = 0;
        pulses = int'(score_flag);
        n_checks++; if (length !== 4'd4 || score !== 4'd1) begin n_fail++;
            $display("FAIL eat_len_score: got %0d %0d exp 4 1", length, score); end
        n_checks++; if (snake[31:0] !== 32'h8B8C8D8E) begin n_fail++;
            $display("FAIL eat_snake: got %h exp 8b8c8d8e", snake[31:0]); end
        n_checks++; if (seg_valid !== 9'h00F) begin n_fail++;
            $display("FAIL eat_valid: got %h exp 00f", seg_valid); end
        step(); pulses += int'(score_flag);
        tick = 1; step(); pulses += int'(score_flag);
        step(); pulses += int'(score_flag); tick = 0;
        n_checks++; if (apple !== 8'h8E) begin n_fail++;
            $display("FAIL eat_reject: got %h exp 8e", apple); end
        rand_num = 8'h35;
        step(); pulses += int'(score_flag);
        n_checks++; if (apple !== 8'h35 || snake[7:0] !== 8'h8E) begin
            n_fail++;
            $display("FAIL eat_place: got %h %h exp 35 8e", apple, snake[7:0]); end
        step(); pulses += int'(score_flag);
        n_checks++; if (snake[7:0] !== 8'h8F) begin n_fail++;
            $display("FAIL eat_pending: got %h exp 8f", snake[7:0]); end
        step(); pulses += int'(score_flag);
        n_checks++; if (snake[7:0] !== 8'h8F) begin n_fail++;
            $display("FAIL eat_drop: got %h exp 8f", snake[7:0]); end
        n_checks++; if (pulses != 1) begin n_fail++;
            $display("FAIL eat_pulse: got %0d exp 1", pulses); end
    endtask

    task automatic test_wall();
        tick = 1; step(); tick = 0;
`ifdef SNAKE_WRAP_EN
        n_checks++; if (snake[7:0] !== 8'h80 || dead_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL wall_wrap: got %h %b exp 80 0", snake[7:0], dead_flag); end
`else
        n_checks++; if (dead_flag !== 1'b1 || snake[7:0] !== 8'h8F) begin
            n_fail++;
            $display("FAIL wall_dead: got %b %h exp 1 8f", dead_flag, snake[7:0]); end
        up = 1; tick = 1; repeat (3) step(); up = 0; tick = 0;
        n_checks++; if (snake[31:0] !== 32'h8C8D8E8F || length !== 4'd4) begin
            n_fail++;
            $display("FAIL wall_frozen: got %h %0d exp 8c8d8e8f 4",
                     snake[31:0], length); end
`endif
    endtask

    task automatic test_self();
        rst = 1; step(); rst = 0;
        right = 1; step(); right = 0;
        rand_num = 8'h8F;
        tick = 1; repeat (6) step(); tick = 0;
        step();
        n_checks++; if (apple !== 8'h8F) begin n_fail++;
            $display("FAIL self_apple: got %h exp 8f", apple); end
        tick = 1; step(); tick = 0;
        rand_num = 8'h00; step();
        n_checks++; if (length !== 4'd5 || score !== 4'd2) begin n_fail++;
            $display("FAIL self_len: got %0d %0d exp 5 2", length, score); end
        up = 1; step(); up = 0; tick = 1; step(); tick = 0;
        left = 1; step(); left = 0; tick = 1; step(); tick = 0;
        n_checks++; if (dead_flag !== 1'b0 || snake[7:0] !== 8'h7E) begin
            n_fail++;
            $display("FAIL self_alive: got %b %h exp 0 7e", dead_flag, snake[7:0]); end
        down = 1; step(); down = 0; tick = 1; step(); tick = 0;
        n_checks++; if (dead_flag !== 1'b1 || snake[7:0] !== 8'h7E) begin
            n_fail++;
            $display("FAIL self_dead: got %b %h exp 1 7e", dead_flag, snake[7:0]); end
    endtask

    task automatic test_random();
        logic [3:0] b;
        rst = 1; step(); rst = 0;
        for (int k = 0; k < 2000; k++) begin
            b = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            {up, right, left, down} = b;
            tick = ($urandom_range(0, 2) == 0);
            rand_num = PW'($urandom);
            rst = ($urandom_range(0, 299) == 0)
               || (m_state >= 3 && $urandom_range(0, 5) == 0);
            step();
            n_checks++; if ((snake & m_pmask()) !== m_vec()) begin n_fail++;
                $display("FAIL rnd_snake@%0d: got %h exp %h", k, snake, m_vec()); end
            n_checks++; if (length !== LW'(m_r.size())
                         || seg_valid !== ML'((1 << m_r.size()) - 1)) begin
                n_fail++;
                $display("FAIL rnd_len@%0d: got %0d %h exp %0d", k, length,
                         seg_valid, m_r.size()); end
            n_checks++; if (apple !== pos(m_ar, m_ac)
                         || score !== SW'(m_score)
                         || score_flag !== m_sflag) begin
                n_fail++;
                $display("FAIL rnd_apple@%0d: got %h %0d %b exp %h %0d %b", k,
                         apple, score, score_flag, pos(m_ar, m_ac), m_score,
                         m_sflag); end
            n_checks++; if (dead_flag !== (m_state == 3)
                         || win_flag !== (m_state == 4)) begin
                n_fail++;
                $display("FAIL rnd_flags@%0d: got %b%b exp %b%b", k, dead_flag,
                         win_flag, m_state == 3, m_state == 4); end
        end
        {up, right, left, down, tick, rst} = '0;
    endtask

    task automatic test_win();
        w_rst = 1; step(); step(); w_rst = 0;
        w_right = 1; step(); w_right = 0;
        w_rand = 8'h35;
        w_tick = 1; repeat (6) step(); w_tick = 0;
        n_checks++; if (w_win !== 1'b1 || w_dead !== 1'b0 || w_length !== 3'd4
                     || w_score !== 4'd1 || w_sflag !== 1'b1) begin
            n_fail++;
            $display("FAIL win_set: got %b%b %0d %0d %b exp 10 4 1 1", w_win,
                     w_dead, w_length, w_score, w_sflag); end
        w_tick = 1; w_right = 1; repeat (3) step(); w_tick = 0; w_right = 0;
        n_checks++; if (w_snake !== 32'h8B8C8D8E || w_apple !== 8'h8E
                     || w_win !== 1'b1) begin
            n_fail++;
            $display("FAIL win_frozen: got %h %h %b exp 8b8c8d8e 8e 1",
                     w_snake, w_apple, w_win); end
        w_rst = 1; step(); w_rst = 0;
        n_checks++; if (w_snake !== 32'h00868788 || w_length !== 3'd3
                     || w_seg_valid !== 4'b0111 || w_win !== 1'b0
                     || w_score !== 4'd0 || w_apple !== 8'h8E) begin
            n_fail++;
            $display("FAIL win_reset: got %h %0d %b %b %0d %h", w_snake,
                     w_length, w_seg_valid, w_win, w_score, w_apple); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_start();
        test_reversal();
        test_eat();
        test_wall();
        test_self();
        test_random();
        test_win();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_core_gen.md
Name: snake_core_gen

Overview:
- Parametrised snake game engine: grid size, maximum length and score width are set by parameters.
- Sits between the button inputs and the VGA, seven-segment and firework blocks.
- Runs on one clock and advances one move per `tick` pulse, replacing the divided-clock game core.
- Adds what the fixed 9-segment core lacks: a start state, reversal rejection, apple re-roll on occupied or out-of-range cells, and a length output with a per-segment valid mask.

Parameters:
- GRID_COLS, 16, playfield columns (>= START_LEN+3).
- GRID_ROWS, 16, playfield rows (>= 2).
- MAX_LEN, 9, maximum snake length; reaching it is a win.
- START_LEN, 3, length after reset (2..MAX_LEN-1).
- SCORE_W, 4, score width.
- Derived: COL_W = clog2(GRID_COLS), ROW_W = clog2(GRID_ROWS), POS_W = ROW_W+COL_W. A position is {row, col}.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  one-cycle move strobe
- up, right, left, down  in  1 each  level direction buttons
- rand_num  in  POS_W  free-running random value
- snake  out  MAX_LEN*POS_W  segment i at [i*POS_W +: POS_W]; i=0 is head
- seg_valid  out  MAX_LEN  bit i=1 when i < length
- length  out  clog2(MAX_LEN+1)  current length
- apple  out  POS_W  apple position
- score  out  SCORE_W  apples eaten, saturating
- score_flag  out  1  one-cycle pulse per apple eaten
- dead_flag  out  1  level, set on death
- win_flag  out  1  level, set on win

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high.
  - State IDLE, dir = RIGHT, length = START_LEN, score = 0, all flags 0.
  - Segment i = {GRID_ROWS/2, GRID_COLS/2 - i} for i < START_LEN; unused segments = 0.
  - apple = {GRID_ROWS/2, GRID_COLS-2}.
  - All outputs registered.
- Direction latch, evaluated every clk:
  - Priority up > right > left > down.
  - A request opposite to the current `dir` is ignored.
  - An accepted request is written to `next_dir`, which is applied at the next move.
- States:
  - IDLE: snake frozen; ticks ignored. The first accepted button press moves to RUN.
  - RUN: on tick, compute head_n from head and next_dir; dir <= next_dir.
    - Out of grid: go to DEAD; snake unchanged.
    - head_n == apple: eat.
      - Shift snake in with head_n and keep the tail; length+1.
      - score+1, saturating at 2^SCORE_W-1; score_flag=1 for one cycle.
      - If the new length == MAX_LEN go to WIN, else go to PLACE.
    - Otherwise: self-collision check against segments 0..length-2 (the tail cell is vacating, so it is legal).
      - Hit: go to DEAD.
      - Else shift; length unchanged.
  - PLACE: each clk, candidate = rand_num.
    - Reject if col >= GRID_COLS, row >= GRID_ROWS, or the candidate equals any valid segment; retry next clk.
    - Accept: apple <= candidate, return to RUN.
    - A tick arriving in PLACE is latched (one deep) and executed on the first RUN cycle. Further ticks in PLACE are dropped.
  - DEAD: dead_flag=1; frozen until rst.
  - WIN: win_flag=1; frozen until rst.
- Move latency: snake, length and score update on the clk after the tick is sampled.
- Simultaneous events:
  - Button press in the same cycle as a tick: the tick uses the prior next_dir; the press takes effect on the following tick.
  - rst has priority over everything, including mid-PLACE and mid-move.

Optional Feature:
- Macro SNAKE_WRAP_EN.
- Defined: leaving the grid wraps to the opposite edge; col 0 <-> GRID_COLS-1, row 0 <-> GRID_ROWS-1. There is no wall death; only self-collision kills.
- Undefined: leaving the grid goes to DEAD as above.

Test Plan:
- Reset and start:
  - Defaults, rst=1 then 0: head {8,8}, seg1 {8,7}, seg2 {8,6}, length=3, apple {8,14}, all flags 0.
  - Ticks before any button: no movement.
  - Press right, then one tick: head {8,9}.
- Reversal: running RIGHT, hold left, then tick -> head col +1; dir stays RIGHT.
- Eat and re-roll:
  - Steer the head to the apple; rand_num = occupied cell for 3 clks, then {3,5}.
  - Required: length=4, score=1, single score_flag pulse, apple = {3,5} exactly 4 clks after the eat update.
- Wall: drive right from col 15 -> dead_flag=1; further ticks change nothing.
  - With SNAKE_WRAP_EN: head -> col 0, alive.
- Self-collision: length 5, sequence up, left, down -> dead_flag=1 on the third tick.
- Win: MAX_LEN=4, START_LEN=3, eat one apple -> win_flag=1, state frozen; rst restores the reset values.
